mips_exec_decode_alu: RTL and testbench
=======================================

Name: mips_exec_decode_alu

Overview:
- Combined main control decoder, ALU-control decoder and ALU for the single-cycle MIPS datapath.
- Takes the fetched instruction and the two register-file read values.
- Produces all datapath control strobes, the ALU result and the zero flag combinationally.
- Also provides a registered copy of result/zero for timing-closed consumers (PC branch logic, debug trace).

Parameters:
- WIDTH, 32, datapath width of operands and result (offset sign-extended to WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- instruction  input  32  current instruction word; opcode [31:26], funct [5:0], offset [15:0].
- read_data1  input  WIDTH  ALU operand A (rs value).
- read_data2  input  WIDTH  ALU operand B (rt value) when alu_src=0.
- branch  output  1  beq strobe.
- mem_read  output  1  data-memory read enable.
- mem_to_reg  output  1  write-back select: 1 = memory data, 0 = ALU result.
- mem_write  output  1  data-memory write enable.
- alu_src  output  1  operand B select: 1 = sign-extended offset, 0 = read_data2.
- reg_write  output  1  register-file write enable.
- reg_dst  output  1  destination select: 1 = rd, 0 = rt.
- alu_op  output  2  main-control to ALU-control code.
- alu_control  output  4  decoded ALU operation.
- alu_result  output  WIDTH  combinational ALU result.
- zero_flag  output  1  combinational; 1 when alu_result == 0.
- alu_result_q  output  WIDTH  alu_result registered on rising clk.
- zero_q  output  1  zero_flag registered on rising clk.

Behaviour:
- Main control (combinational, from opcode):
  - 000000 R-type: reg_dst=1, reg_write=1, alu_op=10, all other strobes 0.
  - 100011 lw: alu_src=1, mem_to_reg=1, reg_write=1, mem_read=1, alu_op=00, others 0.
  - 101011 sw: alu_src=1, mem_write=1, alu_op=00, others 0.
  - 000100 beq: branch=1, alu_op=01, others 0.
  - Any other opcode: every strobe 0 and alu_op=00. No register write, no memory access.
- ALU control (combinational):
  - alu_op 00 → 0010 (add).
  - alu_op 01 → 0110 (sub).
  - alu_op 11 → 0010 (add).
  - alu_op 10 decodes funct:
    - 100000 add → 0010
    - 100010 sub → 0110
    - 100100 and → 0000
    - 100101 or → 0001
    - 101010 slt → 0111
    - 100111 nor → 1100
    - any other funct → 1111
- ALU (combinational):
  - B = alu_src ? sign-extend(instruction[15:0]) to WIDTH : read_data2.
  - 0010 → A+B; 0110 → A−B. Both modulo 2^WIDTH; overflow and carry discarded, no exception.
  - 0000 → A&B; 0001 → A|B; 1100 → ~(A|B).
  - 0111 → 1 if signed(A) < signed(B), else 0, zero-extended.
  - 1111 or any undefined code → result 0.
  - zero_flag = (alu_result == 0). It is therefore 1 for the 1111 code.
- Registered outputs:
  - On every rising clk: alu_result_q <= alu_result, zero_q <= zero_flag. Latency is 1 cycle; no enable.
  - While reset is high: alu_result_q = 0 and zero_q = 0, applied immediately (asynchronous), independent of clk.
  - Reset mid-operation clears the registers at once. The first rising edge after reset deasserts captures the current combinational values.
- Combinational outputs are unaffected by reset; they always reflect the current inputs.
- No internal state besides the two registers; no handshake.

Test Plan:
- R-type add: instruction=0x012A4020, read_data1=5, read_data2=7 → reg_dst=1, reg_write=1, alu_op=10, alu_control=0010, alu_result=12, zero_flag=0; alu_result_q=12 after next rising edge.
- sub and slt:
  - sub (funct 100010), A=7, B=7 → alu_result=0, zero_flag=1.
  - slt (funct 101010), A=0xFFFFFFFF, B=1 → alu_result=1 (signed compare).
- lw with negative offset: instruction=0x8C48FFFC, read_data1=0x100 → alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1, reg_dst=0, alu_result=0xFC.
- sw and beq:
  - sw instruction=0xAC480008, read_data1=0x20 → mem_write=1, reg_write=0, alu_result=0x28.
  - beq with A=B=3 → branch=1, alu_control=0110, zero_flag=1.
- Undefined opcode/funct:
  - opcode 111111 → all strobes 0, alu_control=0010.
  - R-type funct 000011 → alu_control=1111, alu_result=0, zero_flag=1.
- Reset: with alu_result_q=12, assert reset between clock edges → alu_result_q=0 and zero_q=0 immediately; combinational outputs remain unchanged; the first edge after release recaptures the live values.

Source files
------------

// File: rtl/mips_exec_decode_alu.sv
// mips_exec_decode_alu: main control, ALU control and ALU for a single-cycle MIPS datapath, plus registered result/zero
module mips_exec_decode_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instruction,
    input  logic [WIDTH-1:0] read_data1,
    input  logic [WIDTH-1:0] read_data2,
    output logic             branch,
    output logic             mem_read,
    output logic             mem_to_reg,
    output logic             mem_write,
    output logic             alu_src,
    output logic             reg_write,
    output logic             reg_dst,
    output logic [1:0]       alu_op,
    output logic [3:0]       alu_control,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero_flag,
    output logic [WIDTH-1:0] alu_result_q,
    output logic             zero_q
);
    logic [5:0]       w_opcode;
    logic [5:0]       w_funct;
    logic [WIDTH-1:0] w_imm;
    logic [WIDTH-1:0] w_b;
    logic             w_lt;
    assign w_opcode = instruction[31:26];
    assign w_funct  = instruction[5:0];
    assign w_imm    = {{(WIDTH-16){instruction[15]}}, instruction[15:0]};
    assign w_b      = alu_src ? w_imm : read_data2;
    assign w_lt     = $signed(read_data1) < $signed(w_b);
    assign zero_flag = (alu_result == '0);
    // Main control: unknown opcodes leave every strobe low so nothing is written
    always_comb begin
        {branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, reg_dst, alu_op} = 9'b0;
        case (w_opcode)
            6'b000000: {reg_dst, reg_write, alu_op} = 4'b1110;
            6'b100011: {alu_src, mem_to_reg, reg_write, mem_read} = 4'b1111;
            6'b101011: {alu_src, mem_write} = 2'b11;
            6'b000100: {branch, alu_op} = 3'b101;
            default: ;
        endcase
    end
    // ALU control: R-type decodes funct, unknown funct maps to 1111 (result forced to 0)
    always_comb begin
        alu_control = 4'b0010;
        if (alu_op == 2'b01)
            alu_control = 4'b0110;
        else if (alu_op == 2'b10)
            case (w_funct)
                6'b100000: alu_control = 4'b0010;
                6'b100010: alu_control = 4'b0110;
                6'b100100: alu_control = 4'b0000;
                6'b100101: alu_control = 4'b0001;
                6'b101010: alu_control = 4'b0111;
                6'b100111: alu_control = 4'b1100;
                default:   alu_control = 4'b1111;
            endcase
    end
    // ALU datapath: wraparound arithmetic, signed set-less-than, undefined codes give 0
    always_comb begin
        alu_result = '0;
        case (alu_control)
            4'b0010: alu_result = read_data1 + w_b;
            4'b0110: alu_result = read_data1 - w_b;
            4'b0000: alu_result = read_data1 & w_b;
            4'b0001: alu_result = read_data1 | w_b;
            4'b1100: alu_result = ~(read_data1 | w_b);
            4'b0111: alu_result = {{(WIDTH-1){1'b0}}, w_lt};
            default: alu_result = '0;
        endcase
    end
    // One-cycle registered copy of result and zero, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_result_q <= '0;
            zero_q       <= 1'b0;
        end else begin
            alu_result_q <= alu_result;
            zero_q       <= zero_flag;
        end
    end
endmodule

// File: tb/tb_mips_exec_decode_alu.sv
// tb_mips_exec_decode_alu: directed checks of decode, ALU and registered outputs
module tb_mips_exec_decode_alu;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction = '0;
    logic [31:0] read_data1 = '0;
    logic [31:0] read_data2 = '0;
    logic        branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, reg_dst, zero_flag, zero_q;
    logic [1:0]  alu_op;
    logic [3:0]  alu_control;
    logic [31:0] alu_result, alu_result_q;
    logic [8:0]  ctrl;
    int checks = 0;
    int errors = 0;

    mips_exec_decode_alu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .instruction(instruction),
        .read_data1(read_data1), .read_data2(read_data2),
        .branch(branch), .mem_read(mem_read), .mem_to_reg(mem_to_reg),
        .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write),
        .reg_dst(reg_dst), .alu_op(alu_op), .alu_control(alu_control),
        .alu_result(alu_result), .zero_flag(zero_flag),
        .alu_result_q(alu_result_q), .zero_q(zero_q)
    );

    always #5 clk = ~clk;
    assign ctrl = {branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, reg_dst, alu_op};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        instruction = ins;
        read_data1  = a;
        read_data2  = b;
        #1;
    endtask

    initial begin
        #2;
        chk("reset_q", alu_result_q, 32'h0);
        chk("reset_zq", {31'b0, zero_q}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        apply(32'h012A4020, 32'd5, 32'd7);
        chk("add_ctrl", {23'b0, ctrl}, {23'b0, 9'b000001110});
        chk("add_aluc", {28'b0, alu_control}, 32'h2);
        chk("add_res", alu_result, 32'd12);
        chk("add_zero", {31'b0, zero_flag}, 32'h0);
        @(posedge clk); #1;
        chk("add_q", alu_result_q, 32'd12);
        chk("add_zq", {31'b0, zero_q}, 32'h0);
        apply(32'h012A4022, 32'd7, 32'd7);
        chk("sub_aluc", {28'b0, alu_control}, 32'h6);
        chk("sub_res", alu_result, 32'h0);
        chk("sub_zero", {31'b0, zero_flag}, 32'h1);
        @(posedge clk); #1;
        chk("sub_zq", {31'b0, zero_q}, 32'h1);
        apply(32'h012A402A, 32'hFFFFFFFF, 32'd1);
        chk("slt_aluc", {28'b0, alu_control}, 32'h7);
        chk("slt_res", alu_result, 32'h1);
        apply(32'h012A402A, 32'd1, 32'hFFFFFFFF);
        chk("slt_rev", alu_result, 32'h0);
        apply(32'h012A4024, 32'h0000F0F0, 32'h0000FF00);
        chk("and_res", alu_result, 32'h0000F000);
        apply(32'h012A4025, 32'h0000F0F0, 32'h0000FF00);
        chk("or_res", alu_result, 32'h0000FFF0);
        apply(32'h012A4027, 32'h0000F0F0, 32'h0000FF00);
        chk("nor_aluc", {28'b0, alu_control}, 32'hC);
        chk("nor_res", alu_result, 32'hFFFF000F);
        apply(32'h012A4020, 32'hFFFFFFFF, 32'd1);
        chk("add_wrap", alu_result, 32'h0);
        chk("add_wrap_z", {31'b0, zero_flag}, 32'h1);
        apply(32'h8C48FFFC, 32'h100, 32'h55);
        chk("lw_ctrl", {23'b0, ctrl}, {23'b0, 9'b011011000});
        chk("lw_res", alu_result, 32'hFC);
        apply(32'hAC480008, 32'h20, 32'h55);
        chk("sw_ctrl", {23'b0, ctrl}, {23'b0, 9'b000110000});
        chk("sw_res", alu_result, 32'h28);
        apply(32'h11280005, 32'd3, 32'd3);
        chk("beq_ctrl", {23'b0, ctrl}, {23'b0, 9'b100000001});
        chk("beq_aluc", {28'b0, alu_control}, 32'h6);
        chk("beq_zero", {31'b0, zero_flag}, 32'h1);
        apply(32'hFC000000, 32'd2, 32'd3);
        chk("undef_op_ctrl", {23'b0, ctrl}, 32'h0);
        chk("undef_op_aluc", {28'b0, alu_control}, 32'h2);
        chk("undef_op_res", alu_result, 32'd5);
        apply(32'h00000003, 32'd9, 32'd4);
        chk("undef_fn_aluc", {28'b0, alu_control}, 32'hF);
        chk("undef_fn_res", alu_result, 32'h0);
        chk("undef_fn_zero", {31'b0, zero_flag}, 32'h1);
        apply(32'h012A4020, 32'd5, 32'd7);
        @(posedge clk); #1;
        chk("pre_rst_q", alu_result_q, 32'd12);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_q", alu_result_q, 32'h0);
        chk("rst_zq", {31'b0, zero_q}, 32'h0);
        chk("rst_comb", alu_result, 32'd12);
        chk("rst_ctrl", {23'b0, ctrl}, {23'b0, 9'b000001110});
        @(negedge clk);
        chk("rst_hold_q", alu_result_q, 32'h0);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_q", alu_result_q, 32'd12);
        chk("post_rst_zq", {31'b0, zero_q}, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
